inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first encoded word.
REQ-002 SHALL have parameter DEPTH, default 1024, number of 32-bit words in the target window.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, input field bundle valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts the bundle this cycle.
REQ-007 SHALL have port imm_type, input, 3, format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
REQ-008 SHALL have ports opcode (7), rd (5), funct3 (3), rs1 (5), rs2 (5), funct7 (7), all inputs, instruction fields.
REQ-009 SHALL have port imm, input, 32, sign-extended immediate value to pack.
REQ-010 SHALL have port addr_clr, input, 1, synchronous rewind of out_addr to BASE_ADDR.
REQ-011 SHALL have port out_valid, output, 1, encoded word valid.
REQ-012 SHALL have port out_ready, input, 1, downstream (IMEM loader) accepts the word.
REQ-013 SHALL have port out_inst, output, 32, encoded RV32I instruction.
REQ-014 SHALL have port out_addr, output, 32, byte address for out_inst.
REQ-015 SHALL have port out_err, output, 1, out_inst is illegal-type or immediate out of range.
REQ-016 SHALL have port err_sticky, output, 1, set by any transferred word with out_err=1; cleared only by reset.

Function
REQ-017 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-018 in_ready SHALL equal !out_valid || out_ready (single output register, no combinational path from in_valid to out_valid).
REQ-019 Latency SHALL be 1 cycle: bundle accepted at edge N appears on out_inst/out_valid after edge N.
REQ-020 While out_valid=1 and out_ready=0, out_inst, out_addr, out_err SHALL hold stable.
REQ-021 Packing (MSB..LSB): R {funct7,rs2,rs1,funct3,rd,opcode}; I {imm[11:0],rs1,funct3,rd,opcode}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
REQ-022 Packing: B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; U {imm[31:12],rd,opcode}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-023 Range error SHALL be flagged when: I/S imm[31:11] not all equal; B imm[31:12] not all equal or imm[0]=1; U imm[11:0]!=0; J imm[31:20] not all equal or imm[0]=1; R never.
REQ-024 On range error the word SHALL still be packed from the truncated bits per REQ-021/022 with out_err=1.
REQ-025 Illegal imm_type SHALL produce out_inst=32'h0000_0013 (NOP) with out_err=1.
REQ-026 out_addr SHALL be BASE_ADDR for the first word and advance by 4 after each output transfer.
REQ-027 After the word at BASE_ADDR+4*(DEPTH-1) transfers, out_addr SHALL wrap to BASE_ADDR.
REQ-028 addr_clr SHALL set out_addr to BASE_ADDR next cycle and take priority over a simultaneous output transfer; a held word's out_addr changes accordingly.
REQ-029 Simultaneous output and input transfer SHALL load the new word with no bubble (full throughput 1 word/cycle).

Reset
REQ-030 rst_n low SHALL immediately force out_valid=0, out_inst=0, out_err=0, err_sticky=0, out_addr=BASE_ADDR, in_ready=1, independent of clk.
REQ-031 Reset mid-operation SHALL discard any held word; no transfer occurs while rst_n=0.
REQ-032 First input transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-033 I: opcode=7'h13, rd=1, rs1=0, funct3=0, imm=5 -> out_inst=32'h0050_0093, out_addr=BASE_ADDR, out_err=0, one cycle later.
REQ-034 B: opcode=7'h63, rs1=1, rs2=2, funct3=0, imm=-4 -> 32'hFE20_8EE3; J: opcode=7'h6F, rd=1, imm=8 -> 32'h0080_00EF; U: opcode=7'h37, rd=5, imm=32'h1234_5000 -> 32'h1234_52B7.
REQ-035 I with imm=2048 -> out_err=1, out_inst[31:20]=12'h800, err_sticky=1 after transfer; imm_type=6 -> out_inst=32'h0000_0013, out_err=1.
REQ-036 Back-pressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_inst/out_addr stable; then out_ready=1 -> one word/cycle, out_addr +4 each.
REQ-037 DEPTH=4: stream 5 words -> out_addr 0,4,8,12,0; addr_clr asserted with a transfer -> next out_addr=BASE_ADDR.
REQ-038 Assert rst_n=0 mid-stream between clock edges -> out_valid=0 and out_addr=BASE_ADDR immediately; first post-reset word at BASE_ADDR.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word behind a
// single valid/ready output register, with a wrapping IMEM byte address.
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  imm_type,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  input  logic        addr_clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic        err_sticky
);

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));
  localparam logic [31:0] NOP       = 32'h0000_0013;

  // {error, word}; out-of-range immediates are still packed from truncated bits
  function automatic logic [32:0] encode_word(
    input logic [2:0]  fmt,
    input logic [6:0]  opc,
    input logic [4:0]  rdv,
    input logic [2:0]  f3,
    input logic [4:0]  r1,
    input logic [4:0]  r2,
    input logic [6:0]  f7,
    input logic signed [31:0] iv
  );
    logic [31:0] w;
    logic        e;
    w = NOP;
    e = 1'b1;
    case (fmt)
      3'd0: begin
        w = {f7, r2, r1, f3, rdv, opc};
        e = 1'b0;
      end
      3'd1: begin
        w = {iv[11:0], r1, f3, rdv, opc};
        e = !((&iv[31:11]) || !(|iv[31:11]));
      end
      3'd2: begin
        w = {iv[11:5], r2, r1, f3, iv[4:0], opc};
        e = !((&iv[31:11]) || !(|iv[31:11]));
      end
      3'd3: begin
        w = {iv[12], iv[10:5], r2, r1, f3, iv[4:1], iv[11], opc};
        e = !((&iv[31:12]) || !(|iv[31:12])) || iv[0];
      end
      3'd4: begin
        w = {iv[31:12], rdv, opc};
        e = |iv[11:0];
      end
      3'd5: begin
        w = {iv[20], iv[10:1], iv[11], iv[19:12], rdv, opc};
        e = !((&iv[31:20]) || !(|iv[31:20])) || iv[0];
      end
      default: ;
    endcase
    return {e, w};
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a);
    return (a == LAST_ADDR) ? BASE_ADDR : a + 32'd4;
  endfunction

  logic [32:0] enc_p0;
  logic        in_xfer;
  logic        out_xfer;

  assign enc_p0   = encode_word(imm_type, opcode, rd, funct3, rs1, rs2, funct7, imm);
  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // stage p0 -> output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_inst   <= '0;
      out_err    <= 1'b0;
      err_sticky <= 1'b0;
      out_addr   <= BASE_ADDR;
    end else begin
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_inst  <= enc_p0[31:0];
        out_err   <= enc_p0[32];
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
      if (out_xfer && out_err)
        err_sticky <= 1'b1;
      if (addr_clr)
        out_addr <= BASE_ADDR;
      else if (out_xfer)
        out_addr <= next_addr(out_addr);
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed RV32I vectors, back-pressure,
// address wrap/clear, asynchronous reset and randomized traffic vs a field-level model.
module tb_inst_encoder;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  imm_type = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        addr_clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic        err_sticky;

  int total = 0;
  int bad = 0;

  logic [32:0] exp_q[$];
  int          exp_idx = 0;
  logic        exp_sticky = 1'b0;

  inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm_type(imm_type), .opcode(opcode), .rd(rd), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm), .addr_clr(addr_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // Reference: word assembled by shifting/masking fields; range from signed bounds
  function automatic logic [32:0] ref_encode(input logic [2:0] t, input logic [31:0] opc,
      input logic [31:0] rdv, input logic [31:0] f3, input logic [31:0] r1,
      input logic [31:0] r2, input logic [31:0] f7, input logic [31:0] iv);
    logic [31:0] w;
    logic        e;
    int          s;
    s = int'(signed'(iv));
    w = 32'h13;
    e = 1'b1;
    case (t)
      3'd0: begin w = opc | rdv << 7 | f3 << 12 | r1 << 15 | r2 << 20 | f7 << 25; e = 1'b0; end
      3'd1: begin
        w = opc | rdv << 7 | f3 << 12 | r1 << 15 | (iv & 32'hFFF) << 20;
        e = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w = opc | (iv & 32'h1F) << 7 | f3 << 12 | r1 << 15 | r2 << 20 | ((iv >> 5) & 32'h7F) << 25;
        e = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = opc | ((iv >> 11) & 32'h1) << 7 | ((iv >> 1) & 32'hF) << 8 | f3 << 12 | r1 << 15
            | r2 << 20 | ((iv >> 5) & 32'h3F) << 25 | ((iv >> 12) & 32'h1) << 31;
        e = (s < -4096) || (s > 4095) || (iv % 2 != 0);
      end
      3'd4: begin
        w = opc | rdv << 7 | (iv & 32'hFFFF_F000);
        e = (iv % 4096) != 0;
      end
      3'd5: begin
        w = opc | rdv << 7 | ((iv >> 12) & 32'hFF) << 12 | ((iv >> 11) & 32'h1) << 20
            | ((iv >> 1) & 32'h3FF) << 21 | ((iv >> 20) & 32'h1) << 31;
        e = (s < -(1 << 20)) || (s >= (1 << 20)) || (iv % 2 != 0);
      end
      default: ;
    endcase
    return {e, w};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_idx = 0;
    exp_sticky = 1'b0;
  endtask

  // One clock: decide transfers from the model, advance the edge, update the model.
  task automatic tick();
    bit          in_x;
    bit          out_x;
    logic [32:0] nw;
    #1;
    in_x  = in_valid && (exp_q.size() == 0 || out_ready);
    out_x = (exp_q.size() != 0) && out_ready;
    nw = ref_encode(imm_type, 32'(opcode), 32'(rd), 32'(funct3), 32'(rs1), 32'(rs2),
                    32'(funct7), imm);
    @(posedge clk);
    if (out_x) begin
      if (exp_q[0][32]) exp_sticky = 1'b1;
      void'(exp_q.pop_front());
    end
    if (addr_clr) exp_idx = 0;
    else if (out_x) exp_idx = (exp_idx + 1) % DEPTH;
    if (in_x) exp_q.push_back(nw);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [6:0] opc, input logic [4:0] rdv,
      input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
      input logic [6:0] f7, input logic [31:0] iv);
    imm_type = t; opcode = opc; rd = rdv; funct3 = f3;
    rs1 = r1; rs2 = r2; funct7 = f7; imm = iv;
  endtask

  task automatic drive_random();
    logic [2:0]  t;
    logic [31:0] v;
    int          r;
    t = 3'($urandom_range(0, 7));
    r = $urandom_range(0, 3);
    v = $urandom;
    if (r != 0) v = 32'(signed'(v) >>> $urandom_range(10, 31));
    if (r >= 2) v[0] = 1'b0;
    if (r >= 2 && t == 3'd4) v = $urandom & 32'hFFFF_F000;
    drive(t, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
          7'($urandom), v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_err !== 1'b0 || err_sticky !== 1'b0
        || out_addr !== BASE || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: valid=%b inst=%h err=%b sticky=%b addr=%h rdy=%b, required 0 0 0 0 %h 1",
               out_valid, out_inst, out_err, err_sticky, out_addr, in_ready, BASE);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [31:0] want[5];
    want[0] = 32'h0050_0093; want[1] = 32'hFE20_8EE3; want[2] = 32'h0080_00EF;
    want[3] = 32'h1234_52B7; want[4] = 32'h8000_0093;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: drive(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        1: drive(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC);
        2: drive(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd8);
        3: drive(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
        default: drive(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
      endcase
      tick();
      total++;
      if (out_valid !== 1'b1 || out_inst !== want[k] || out_err !== (k == 4)
          || out_addr !== BASE + 32'(4 * (k % DEPTH))) begin
        bad++;
        $display("FAIL vector_%0d: valid=%b inst=%h err=%b addr=%h, required 1 %h %b %h",
                 k, out_valid, out_inst, out_err, out_addr, want[k], k == 4,
                 BASE + 32'(4 * (k % DEPTH)));
      end
    end
    total++;
    if (err_sticky !== 1'b0) begin
      bad++;
      $display("FAIL sticky_before_xfer: got %b, required 0", err_sticky);
    end
    drive(3'd6, 7'h33, 5'd3, 3'd1, 5'd4, 5'd5, 7'd0, 32'd0);
    tick();
    total++;
    if (out_inst !== 32'h0000_0013 || out_err !== 1'b1 || err_sticky !== 1'b1) begin
      bad++;
      $display("FAIL illegal_type: inst=%h err=%b sticky=%b, required 00000013 1 1",
               out_inst, out_err, err_sticky);
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL drain: valid=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held_inst;
    logic [31:0] held_addr;
    logic [31:0] prev_addr;
    in_valid = 1'b1;
    out_ready = 1'b0;
    drive_random();
    tick();
    held_inst = out_inst;
    held_addr = out_addr;
    total++;
    if (out_valid !== 1'b1 || out_inst !== exp_q[0][31:0] || out_addr !== BASE + 32'(4 * exp_idx)) begin
      bad++;
      $display("FAIL bp_load: valid=%b inst=%h addr=%h, required 1 %h %h",
               out_valid, out_inst, out_addr, exp_q[0][31:0], BASE + 32'(4 * exp_idx));
    end
    for (int k = 0; k < 5; k++) begin
      drive_random();
      tick();
      total++;
      if (in_ready !== 1'b0 || out_inst !== held_inst || out_addr !== held_addr) begin
        bad++;
        $display("FAIL bp_hold_%0d: rdy=%b inst=%h addr=%h, required 0 %h %h",
                 k, in_ready, out_inst, out_addr, held_inst, held_addr);
      end
    end
    out_ready = 1'b1;
    prev_addr = out_addr;
    for (int k = 0; k < 4; k++) begin
      drive_random();
      tick();
      total++;
      if (out_valid !== 1'b1 || out_addr !== (prev_addr + 32'd4) % (4 * DEPTH)
          || out_inst !== exp_q[0][31:0]) begin
        bad++;
        $display("FAIL bp_stream_%0d: valid=%b addr=%h inst=%h, required 1 %h %h", k,
                 out_valid, out_addr, out_inst, (prev_addr + 32'd4) % (4 * DEPTH), exp_q[0][31:0]);
      end
      prev_addr = out_addr;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_wrap_clear();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_random();
      tick();
      total++;
      if (out_addr !== BASE + 32'(4 * (k % 4))) begin
        bad++;
        $display("FAIL wrap_addr_%0d: got %h, required %h", k, out_addr, BASE + 32'(4 * (k % 4)));
      end
    end
    addr_clr = 1'b1;
    drive_random();
    tick();
    addr_clr = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_addr !== BASE) begin
      bad++;
      $display("FAIL addr_clr: valid=%b addr=%h, required 1 %h", out_valid, out_addr, BASE);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_random();
      tick();
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (out_valid !== 1'b0 || out_addr !== BASE || out_inst !== 32'h0 || in_ready !== 1'b1
        || err_sticky !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: valid=%b addr=%h inst=%h rdy=%b sticky=%b, required 0 %h 0 1 0",
               out_valid, out_addr, out_inst, in_ready, err_sticky, BASE);
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL no_xfer_in_reset: valid=%b, required 0", out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_random();
    tick();
    total++;
    if (out_valid !== 1'b1 || out_addr !== BASE || out_inst !== exp_q[0][31:0]) begin
      bad++;
      $display("FAIL first_after_reset: valid=%b addr=%h inst=%h, required 1 %h %h",
               out_valid, out_addr, out_inst, BASE, exp_q[0][31:0]);
    end
  endtask

  task automatic test_random();
    int fails_here;
    fails_here = 0;
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      addr_clr  = ($urandom_range(0, 19) == 0);
      drive_random();
      #1;
      total++;
      if (in_ready !== (exp_q.size() == 0 || out_ready)) begin
        bad++;
        $display("FAIL rand_ready_%0d: got %b, required %b", k, in_ready,
                 exp_q.size() == 0 || out_ready);
      end
      tick();
      total++;
      if (out_valid !== (exp_q.size() != 0) || out_addr !== BASE + 32'(4 * exp_idx)
          || err_sticky !== exp_sticky
          || (exp_q.size() != 0 && (out_inst !== exp_q[0][31:0] || out_err !== exp_q[0][32]))) begin
        bad++;
        if (fails_here < 10)
          $display("FAIL rand_out_%0d: valid=%b inst=%h err=%b addr=%h sticky=%b, required %b %h %b %h %b",
                   k, out_valid, out_inst, out_err, out_addr, err_sticky, exp_q.size() != 0,
                   exp_q.size() != 0 ? exp_q[0][31:0] : 32'h0, exp_q.size() != 0 ? exp_q[0][32] : 1'b0,
                   BASE + 32'(4 * exp_idx), exp_sticky);
        fails_here++;
      end
    end
    addr_clr = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_wrap_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
